// File: rtl/hash_arbiter_pkg.sv
// Shared definitions for the hash arbiter: FSM encoding and datapath widths.
package hash_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int HASH_W   = 24;
  localparam int NONCE_W  = 32;
  localparam int JOBCNT_W = 16;
  localparam int WAIT_W   = 8;

endpackage

// File: rtl/hash_arbiter_rr_select.sv
// Round-robin selector: picks the first requester after the last granted
// index, wrapping around. Purely combinational, one-hot result.
module rr_select #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] win
);

  int  idx_s;
  logic found_s;

  // Scan from last+1 through last (inclusive, wrapped) and keep the first hit.
  always_comb begin
    win     = '0;
    found_s = 1'b0;
    idx_s   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_s = (int'(last) + k) % NUM_REQ;
      if (!found_s && req[idx_s]) begin
        win[idx_s] = 1'b1;
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/hash_arbiter.sv
// hash_arbiter: shares one fixed-latency hash engine among NUM_REQ requesters.
// Optional feature macro: HASH_ARB_JOBCNT_EN enables the 16-bit completed-job
// counter on jobs_done; without it jobs_done is tied to zero.
module hash_arbiter
  import hash_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int HASH_LATENCY = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*32-1:0]  req_nonce,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic [HASH_W-1:0]      hash_out,
  output logic [NONCE_W-1:0]     eng_nonce,
  output logic                   eng_ready,
  input  logic [HASH_W-1:0]      eng_hash,
  output logic                   busy,
  output logic [JOBCNT_W-1:0]    jobs_done
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t               state_r, state_s;
  logic [NUM_REQ-1:0]   gnt_r, done_r, win_s;
  logic [HASH_W-1:0]    hash_r;
  logic [NONCE_W-1:0]   nonce_r, win_nonce_s;
  logic                 ready_r;
  logic [IDX_W-1:0]     ptr_r, win_idx_s;
  logic [WAIT_W-1:0]    cnt_r;

  rr_select #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req  (req),
    .last (ptr_r),
    .win  (win_s)
  );

  // Convert the one-hot winner into an index and pick its nonce (AND-OR mux).
  always_comb begin
    win_nonce_s = '0;
    win_idx_s   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      win_nonce_s = win_nonce_s | ({NONCE_W{win_s[k]}} & req_nonce[k*NONCE_W +: NONCE_W]);
      win_idx_s   = win_s[k] ? IDX_W'(k) : win_idx_s;
    end
  end

  // Next-state logic: IDLE -> ISSUE -> WAIT (HASH_LATENCY cycles) -> DONE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (|req) state_s = ST_ISSUE;
        else      state_s = ST_IDLE;
      end
      ST_ISSUE: state_s = ST_WAIT;
      ST_WAIT: begin
        if (cnt_r == {WAIT_W{1'b0}}) state_s = ST_DONE;
        else                          state_s = ST_WAIT;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Datapath registers: grant, engine handshake, wait counter, result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_r   <= '0;
      done_r  <= '0;
      hash_r  <= '0;
      nonce_r <= '0;
      ready_r <= 1'b0;
      ptr_r   <= IDX_W'(NUM_REQ - 1);
      cnt_r   <= '0;
    end else begin
      ready_r <= 1'b0;
      done_r  <= '0;
      case (state_r)
        ST_IDLE: begin
          if (state_s == ST_ISSUE) begin
            gnt_r   <= win_s;
            nonce_r <= win_nonce_s;
            ready_r <= 1'b1;
            ptr_r   <= win_idx_s;
          end
        end
        ST_ISSUE: cnt_r <= WAIT_W'(HASH_LATENCY - 1);
        ST_WAIT: begin
          if (cnt_r == {WAIT_W{1'b0}}) begin
            // Result is captured even if the requester has dropped out.
            hash_r <= eng_hash;
            gnt_r  <= '0;
            done_r <= gnt_r & req;
          end else begin
            cnt_r <= cnt_r - WAIT_W'(1);
          end
        end
        ST_DONE: nonce_r <= '0;
        default: nonce_r <= '0;
      endcase
    end
  end

`ifdef HASH_ARB_JOBCNT_EN
  logic [JOBCNT_W-1:0] jobs_cnt_r;

  // Count jobs whose requester is still present when the result arrives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      jobs_cnt_r <= '0;
    end else if (state_r == ST_WAIT && cnt_r == {WAIT_W{1'b0}} && |(gnt_r & req)) begin
      jobs_cnt_r <= jobs_cnt_r + JOBCNT_W'(1);
    end
  end

  assign jobs_done = jobs_cnt_r;
`else
  assign jobs_done = {JOBCNT_W{1'b0}};
`endif

  assign gnt       = gnt_r;
  assign done      = done_r;
  assign hash_out  = hash_r;
  assign eng_nonce = nonce_r;
  assign eng_ready = ready_r;
  assign busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_hash_arbiter.sv
// Self-checking bench for hash_arbiter (NUM_REQ=4, HASH_LATENCY=10).
module tb_hash_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [127:0] req_nonce;
  logic [3:0]   gnt, done;
  logic [23:0]  hash_out, eng_hash;
  logic [31:0]  eng_nonce;
  logic         eng_ready, busy;
  logic [15:0]  jobs_done;
  logic [31:0]  cyc = 32'd0;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_jobs = 16'd0;

  typedef struct {
    logic [3:0]  gnt;
    logic [31:0] nonce;
    logic [23:0] hash;
    logic [3:0]  done;
    logic [15:0] jobs;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [3:0] req_v;
    logic       drop;
    logic [3:0] exp_gnt;
  } vec_t;
  vec_t vecs[6];

  hash_arbiter #(.NUM_REQ(4), .HASH_LATENCY(10)) dut (
    .clk(clk), .reset(reset), .req(req), .req_nonce(req_nonce),
    .gnt(gnt), .done(done), .hash_out(hash_out), .eng_nonce(eng_nonce),
    .eng_ready(eng_ready), .eng_hash(eng_hash), .busy(busy), .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // Engine model: result is a distinct function of the cycle it is sampled in.
  function automatic logic [23:0] hf(input logic [31:0] c);
    return {c[7:0] ^ 8'hA5, c[15:0]};
  endfunction
  assign eng_hash = hf(cyc);

  function automatic logic [31:0] nonce_of(input logic [3:0] oh);
    logic [31:0] r;
    r = 32'd0;
    for (int k = 0; k < 4; k++) if (oh[k]) r = req_nonce[k*32 +: 32];
    return r;
  endfunction

  function automatic logic [15:0] exp_jd();
`ifdef HASH_ARB_JOBCNT_EN
    return exp_jobs;
`else
    return 16'd0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One full job; called at a negedge with the DUT idle.
  task automatic run_job(input logic [3:0] req_v, input logic drop, input logic [3:0] exp_gnt);
    exp_t e;
    req = req_v;
    @(negedge clk);
    chk("issue_gnt", {28'd0, gnt}, {28'd0, exp_gnt});
    chk("issue_ready", {31'd0, eng_ready}, 32'd1);
    chk("issue_nonce", eng_nonce, nonce_of(exp_gnt));
    chk("issue_busy", {31'd0, busy}, 32'd1);
    if (!drop) exp_jobs = exp_jobs + 16'd1;
    e.gnt = exp_gnt; e.nonce = nonce_of(exp_gnt); e.hash = hf(cyc + 32'd10);
    e.done = drop ? 4'b0000 : exp_gnt; e.jobs = exp_jd();
    sbq.push_back(e);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (drop && n == 3) req = 4'b0000;
      if (n == 1) chk("ready_pulse", {31'd0, eng_ready}, 32'd0);
      if (n == 5) chk("wait_nonce", eng_nonce, e.nonce);
      if (n == 5) chk("wait_gnt", {28'd0, gnt}, {28'd0, e.gnt});
    end
    @(negedge clk);
    e = sbq.pop_front();
    chk("done_gnt", {28'd0, gnt}, 32'd0);
    chk("done_pulse", {28'd0, done}, {28'd0, e.done});
    chk("done_hash", {8'd0, hash_out}, {8'd0, e.hash});
    chk("done_jobs", {16'd0, jobs_done}, {16'd0, e.jobs});
    chk("done_nonce", eng_nonce, e.nonce);
    req = 4'b0000;
    @(negedge clk);
    chk("idle_done", {28'd0, done}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_nonce", eng_nonce, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  order[5];
    logic [31:0] prev;
    int t;
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;
    vecs[0] = '{4'b0010, 1'b0, 4'b0010};
    vecs[1] = '{4'b0011, 1'b0, 4'b0001};
    vecs[2] = '{4'b1010, 1'b0, 4'b0010};
    vecs[3] = '{4'b1010, 1'b0, 4'b1000};
    vecs[4] = '{4'b0001, 1'b1, 4'b0001};
    vecs[5] = '{4'b1111, 1'b0, 4'b0010};

    reset = 1'b0;
    req = 4'b0000;
    req_nonce = {32'h0BADF00D, 32'hCAFEF00D, 32'hDEADBEEF, 32'h12345678};
    repeat (2) @(negedge clk);
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_done", {28'd0, done}, 32'd0);
    chk("rst_ready", {31'd0, eng_ready}, 32'd0);
    chk("rst_nonce", eng_nonce, 32'd0);
    chk("rst_hash", {8'd0, hash_out}, 32'd0);
    chk("rst_jobs", {16'd0, jobs_done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_job(vecs[i].req_v, vecs[i].drop, vecs[i].exp_gnt);

    // Reset in the middle of WAIT.
    req = 4'b0001;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    req = 4'b0000;
    #1;
    chk("mid_rst_gnt", {28'd0, gnt}, 32'd0);
    chk("mid_rst_nonce", eng_nonce, 32'd0);
    chk("mid_rst_hash", {8'd0, hash_out}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_jobs", {16'd0, jobs_done}, 32'd0);
    exp_jobs = 16'd0;
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_done", {28'd0, done}, 32'd0);
    end
    reset = 1'b1;
    run_job(4'b1100, 1'b0, 4'b0100);
    run_job(4'b1000, 1'b0, 4'b1000);

    // All requesting: rotation order and 13-cycle spacing.
    req = 4'b1111;
    prev = 32'd0;
    for (int g = 0; g < 5; g++) begin
      t = 0;
      while (gnt == 4'b0000 && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("rr_gnt", {28'd0, gnt}, {28'd0, order[g]});
      if (g > 0) chk("rr_spacing", cyc - prev, 32'd13);
      prev = cyc;
      if (g < 4) begin
        repeat (11) @(negedge clk);
        exp_jobs = exp_jobs + 16'd1;
        chk("rr_done", {28'd0, done}, {28'd0, order[g]});
        chk("rr_hash", {8'd0, hash_out}, {8'd0, hf(prev + 32'd10)});
        if (g == 3) chk("rr_jobs4", {16'd0, jobs_done}, {16'd0, exp_jd()});
      end else begin
        req = 4'b0000;
        repeat (11) @(negedge clk);
        chk("rr_abort_done", {28'd0, done}, 32'd0);
        chk("rr_abort_hash", {8'd0, hash_out}, {8'd0, hf(prev + 32'd10)});
        @(negedge clk);
        chk("rr_abort_jobs", {16'd0, jobs_done}, {16'd0, exp_jd()});
      end
    end

`ifdef HASH_ARB_JOBCNT_EN
    force dut.jobs_cnt_r = 16'hFFFF;
    @(negedge clk);
    release dut.jobs_cnt_r;
    exp_jobs = 16'hFFFF;
`endif
    run_job(4'b0001, 1'b0, 4'b0001);
    chk("wrap_jobs", {16'd0, jobs_done}, {16'd0, exp_jd()});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
